// File: rtl/dsm_output_serializer.sv
// dsm_output_serializer: frames each 24-bit decimated sample as a strobe pulse
// followed by three timed byte slots (MSB, middle, LSB) on an 8-bit lane.
// A one-deep holding buffer absorbs a sample arriving mid-frame; a sticky
// flag records samples dropped because the buffer was already occupied.
module dsm_output_serializer #(
    parameter int unsigned LEAD_CYCLES   = 24,
    parameter int unsigned STROBE_CYCLES = 8,
    parameter int unsigned BYTE_CYCLES   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_in_valid,
    input  logic [23:0] i_in_data,
    output logic [7:0]  o_data_out,
    output logic        o_strobe,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam logic [7:0] LeadLast  = 8'(LEAD_CYCLES - 1);
    localparam logic [7:0] ByteLast  = 8'(BYTE_CYCLES - 1);
    localparam logic [7:0] StrobeLen = 8'(STROBE_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StByte2,
        StByte1,
        StByte0
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [23:0] r_word, w_word_nxt;
    logic [23:0] r_buf, w_buf_nxt;
    logic        r_buf_full, w_buf_full_nxt;
    logic        r_overrun, w_overrun_nxt;

    logic [7:0]  r_data_out, w_data_nxt;
    logic        r_strobe, w_strobe_nxt;
    logic        r_busy, w_busy_nxt;

    logic        w_accept;
    logic        w_frame_end;

    assign w_accept    = i_in_valid & i_en;
    assign w_frame_end = (r_state == StByte0) && (r_cnt == ByteLast);

    // State register plus shift word, holding buffer and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_word     <= 24'd0;
            r_buf      <= 24'd0;
            r_buf_full <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word     <= w_word_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // Next-state logic: slot sequencing, buffer fill/drain and drop detection
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + 8'd1;
        w_word_nxt     = r_word;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_overrun_nxt  = r_overrun;

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = 8'd0;
                if (w_accept) begin
                    w_word_nxt  = i_in_data;
                    w_state_nxt = StLead;
                end
            end
            StLead: begin
                if (r_cnt == LeadLast) begin
                    w_state_nxt = StByte2;
                    w_cnt_nxt   = 8'd0;
                end
            end
            StByte2: begin
                if (r_cnt == ByteLast) begin
                    w_state_nxt = StByte1;
                    w_cnt_nxt   = 8'd0;
                end
            end
            StByte1: begin
                if (r_cnt == ByteLast) begin
                    w_state_nxt = StByte0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            StByte0: begin
                if (w_frame_end) begin
                    w_cnt_nxt = 8'd0;
                    if (r_buf_full) begin
                        // Drain the buffer; a sample arriving now refills it
                        w_word_nxt  = r_buf;
                        w_state_nxt = StLead;
                        if (w_accept) begin
                            w_buf_nxt = i_in_data;
                        end else begin
                            w_buf_full_nxt = 1'b0;
                        end
                    end else if (w_accept) begin
                        // Empty buffer: the new sample goes straight into the next frame
                        w_word_nxt  = i_in_data;
                        w_state_nxt = StLead;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        // Mid-frame arrivals: fill the buffer, or drop and flag when occupied
        if ((r_state != StIdle) && !w_frame_end && w_accept) begin
            if (r_buf_full) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_buf_nxt      = i_in_data;
                w_buf_full_nxt = 1'b1;
            end
        end
    end

    // Output decode from the next state so the pins are registered
    always_comb begin
        w_data_nxt   = 8'h00;
        w_strobe_nxt = 1'b0;
        w_busy_nxt   = (w_state_nxt != StIdle);
        unique case (w_state_nxt)
            StLead:  w_strobe_nxt = (w_cnt_nxt < StrobeLen);
            StByte2: w_data_nxt   = w_word_nxt[23:16];
            StByte1: w_data_nxt   = w_word_nxt[15:8];
            StByte0: w_data_nxt   = w_word_nxt[7:0];
            default: w_data_nxt   = 8'h00;
        endcase
    end

    // Output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_out <= 8'h00;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_data_out <= w_data_nxt;
            r_strobe   <= w_strobe_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign o_data_out = r_data_out;
    assign o_strobe   = r_strobe;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule
